// File: rtl/ps2_tx_pkg.sv
// Shared constants, FSM encoding and frame builder for the PS/2 device-side transmitter.
package ps2_tx_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam int         FRAME_BITS = 11;

    typedef enum logic [2:0] {IDLE, BIT_HI, BIT_LO, GAP, INHIBIT} tx_state_t;

    // Shift-out order from bit 0: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO between the scancode sequencer and the frame transmitter.
module ps2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [7:0]               wdata,
    input  logic                     rd,
    output logic [7:0]               rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    // A pop frees the head slot in the same cycle, so a full FIFO may still accept a write.
    assign do_rd = rd && (count != '0);
    assign do_wr = wr && ((count != CAP) || do_rd);

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign free  = CAP - count;

    always_ff @(posedge clk_sys) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_transmitter.sv
// Turns hps_io ps2_key events into Set-2 scancode bytes and sends them as PS/2 device frames.
//   state   | meaning
//   IDLE    | lines released, waiting for a queued byte and a released clock line
//   BIT_HI  | clock released, current bit on data, host inhibit watched
//   BIT_LO  | clock driven low, data held
//   GAP     | lines released between frames
//   INHIBIT | host held clock low; wait for GAP consecutive high cycles, then resend
module ps2_key_transmitter
    import ps2_tx_pkg::*;
#(
    parameter int HALF  = 1500,
    parameter int GAP   = 3000,
    parameter int DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        ps2_kbd_clk_in,
    output logic        ps2_kbd_clk_out,
    output logic        ps2_kbd_dat_out,
    output logic        busy,
    output logic        overflow
);
    localparam int FW   = $clog2(DEPTH) + 1;
    localparam int TMAX = (HALF > GAP) ? HALF : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HALF_TC = TW'(HALF - 1);
    localparam logic [TW-1:0] GAP_TC  = TW'(GAP - 1);
    localparam logic [3:0]    LAST_IDX = 4'(FRAME_BITS - 1);

    logic          last_tog;
    logic [1:0]    pend_cnt;
    logic [7:0]    pend0;
    logic [7:0]    pend1;
    logic [1:0]    ev_n;
    logic [7:0]    ev_b0;
    logic [7:0]    ev_b1;
    logic [7:0]    ev_b2;
    logic          detect;
    logic          fits;
    logic          fifo_wr;
    logic [7:0]    fifo_wdata;
    logic          fifo_rd;
    logic [7:0]    fifo_head;
    logic          fifo_empty;
    logic [FW-1:0] fifo_free;

    tx_state_t            state;
    logic [TW-1:0]        tmr;
    logic [3:0]           idx;
    logic [FRAME_BITS-1:0] frame;

    always_comb begin
        ev_n  = 2'd1;
        ev_b0 = ps2_key[7:0];
        ev_b1 = 8'h00;
        ev_b2 = 8'h00;
        if (ps2_key[8] && !ps2_key[9]) begin
            ev_n  = 2'd3;
            ev_b0 = PS2_EXT;
            ev_b1 = PS2_BRK;
            ev_b2 = ps2_key[7:0];
        end else if (ps2_key[8]) begin
            ev_n  = 2'd2;
            ev_b0 = PS2_EXT;
            ev_b1 = ps2_key[7:0];
        end else if (!ps2_key[9]) begin
            ev_n  = 2'd2;
            ev_b0 = PS2_BRK;
            ev_b1 = ps2_key[7:0];
        end
    end

    // The first byte of an accepted event goes straight into the FIFO; the rest follow from pend0/pend1.
    assign detect     = (pend_cnt == 2'd0) && (ps2_key[10] != last_tog);
    assign fits       = (fifo_free >= FW'(ev_n));
    assign fifo_wr    = (detect && fits) || (pend_cnt != 2'd0);
    assign fifo_wdata = (pend_cnt != 2'd0) ? pend0 : ev_b0;
    assign fifo_rd    = (state == BIT_LO) && (tmr == '0) && (idx == LAST_IDX);
    assign busy       = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_tog <= ps2_key[10];
            pend_cnt <= 2'd0;
            pend0    <= 8'h00;
            pend1    <= 8'h00;
            overflow <= 1'b0;
        end else begin
            overflow <= detect && !fits;
            if (detect) begin
                last_tog <= ps2_key[10];
                if (fits) begin
                    pend0    <= ev_b1;
                    pend1    <= ev_b2;
                    pend_cnt <= ev_n - 2'd1;
                end
            end else if (pend_cnt != 2'd0) begin
                pend0    <= pend1;
                pend_cnt <= pend_cnt - 2'd1;
            end
        end
    end

    ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr      (fifo_wr),
        .wdata   (fifo_wdata),
        .rd      (fifo_rd),
        .rdata   (fifo_head),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= IDLE;
            tmr             <= '0;
            idx             <= 4'd0;
            frame           <= '1;
            ps2_kbd_clk_out <= 1'b1;
            ps2_kbd_dat_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ps2_kbd_clk_out <= 1'b1;
                    ps2_kbd_dat_out <= 1'b1;
                    if (!fifo_empty && ps2_kbd_clk_in) begin
                        frame           <= make_frame(fifo_head);
                        idx             <= 4'd0;
                        tmr             <= HALF_TC;
                        ps2_kbd_dat_out <= 1'b0;
                        state           <= BIT_HI;
                    end
                end
                BIT_HI: begin
                    if (!ps2_kbd_clk_in && (idx <= 4'd9)) begin
                        ps2_kbd_clk_out <= 1'b1;
                        ps2_kbd_dat_out <= 1'b1;
                        tmr             <= GAP_TC;
                        state           <= INHIBIT;
                    end else if (tmr == '0) begin
                        ps2_kbd_clk_out <= 1'b0;
                        tmr             <= HALF_TC;
                        state           <= BIT_LO;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                BIT_LO: begin
                    if (tmr == '0) begin
                        ps2_kbd_clk_out <= 1'b1;
                        if (idx == LAST_IDX) begin
                            ps2_kbd_dat_out <= 1'b1;
                            tmr             <= GAP_TC;
                            state           <= ps2_tx_pkg::GAP;
                        end else begin
                            idx             <= idx + 4'd1;
                            frame           <= frame >> 1;
                            ps2_kbd_dat_out <= frame[1];
                            tmr             <= HALF_TC;
                            state           <= BIT_HI;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ps2_tx_pkg::GAP: begin
                    if (tmr == '0) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                INHIBIT: begin
                    if (!ps2_kbd_clk_in) begin
                        tmr <= GAP_TC;
                    end else if (tmr == '0) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_transmitter.sv
// Directed bench for ps2_key_transmitter: decodes the device frames and checks bytes and timing.
module tb_ps2_key_transmitter;
    localparam int HALF  = 4;
    localparam int GAP   = 8;
    localparam int DEPTH = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'h000;
    logic        host_clk = 1'b1;
    logic        ps2_kbd_clk_in;
    logic        ps2_kbd_clk_out;
    logic        ps2_kbd_dat_out;
    logic        busy;
    logic        overflow;

    assign ps2_kbd_clk_in = host_clk & ps2_kbd_clk_out;

    ps2_key_transmitter #(.HALF(HALF), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ps2_key         (ps2_key),
        .ps2_kbd_clk_in  (ps2_kbd_clk_in),
        .ps2_kbd_clk_out (ps2_kbd_clk_out),
        .ps2_kbd_dat_out (ps2_kbd_dat_out),
        .busy            (busy),
        .overflow        (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Host-side receiver: samples data on each falling clock, aborts a frame after a long high run.
    logic [7:0]  rx_q[$];
    bit          rx_ok_q[$];
    int          rx_start_q[$];
    int          rx_end_q[$];
    int          rx_fall_q[$];
    int          rx_n = 0;
    int          hi_run = 0;
    int          cur_start = 0;
    int          cur_fall = 0;
    int          fall_cnt = 0;
    int          ovf_cnt = 0;
    logic [10:0] rx_sh = '0;
    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;

    always @(negedge clk_sys) begin
        if (overflow === 1'b1) ovf_cnt++;
        if (reset) begin
            rx_n = 0;
            hi_run = 0;
        end else begin
            if (prev_dat && !ps2_kbd_dat_out && ps2_kbd_clk_out && rx_n == 0) cur_start = cyc;
            if (prev_clk && !ps2_kbd_clk_out) begin
                fall_cnt++;
                if (rx_n == 0) cur_fall = cyc;
                if (rx_n < 11) begin
                    rx_sh[rx_n] = ps2_kbd_dat_out;
                    rx_n++;
                end
            end
            if (!prev_clk && ps2_kbd_clk_out && rx_n == 11) begin
                rx_q.push_back(rx_sh[8:1]);
                rx_ok_q.push_back(rx_sh[0] == 1'b0 && rx_sh[10] == 1'b1 && rx_sh[9] == (~^rx_sh[8:1]));
                rx_start_q.push_back(cur_start);
                rx_end_q.push_back(cyc);
                rx_fall_q.push_back(cur_fall);
                rx_n = 0;
            end
            hi_run = ps2_kbd_clk_out ? hi_run + 1 : 0;
            if (hi_run > 6) rx_n = 0;
        end
        prev_clk = ps2_kbd_clk_out;
        prev_dat = ps2_kbd_dat_out;
    end

    int tests = 0;
    int fails = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic flip(input logic ext, input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        step(2);
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        if (busy) chk({name, " idle timeout"}, 1, 0);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_ok_q.delete();
        rx_start_q.delete();
        rx_end_q.delete();
        rx_fall_q.delete();
    endtask

    typedef struct {
        logic       ext;
        logic       pressed;
        logic [7:0] code;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        int r;
        int o0;
        int f0;
        logic [7:0] eb[3];
        logic [7:0] exp_b;

        vecs[0] = '{1'b0, 1'b1, 8'h1C, 1, 8'h1C, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h75, 3, 8'hE0, 8'hF0, 8'h75};
        vecs[2] = '{1'b1, 1'b1, 8'h6B, 2, 8'hE0, 8'h6B, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 8'h1C, 2, 8'hF0, 8'h1C, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 1, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h5A, 3, 8'hE0, 8'hF0, 8'h5A};

        step(3);
        chk("reset clk_out", ps2_kbd_clk_out, 1);
        chk("reset dat_out", ps2_kbd_dat_out, 1);
        chk("reset busy", busy, 0);
        chk("reset overflow", overflow, 0);
        reset = 1'b0;
        step(3);

        // Single make code: latency, frame length, busy release.
        clear_rx();
        t0 = cyc;
        flip(1'b0, 1'b1, 8'h1C);
        step(1);
        chk("t1 busy at T+1", busy, 1);
        chk("t1 overflow at T+1", overflow, 0);
        chk("t1 clk_out at T+1", ps2_kbd_clk_out, 1);
        k = 0;
        while (busy && k < 300) begin
            step(1);
            k++;
        end
        chk("t1 busy clear cycle", cyc - t0, 98);
        chk("t1 frame count", rx_q.size(), 1);
        chk("t1 byte", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 8'h1C);
        chk("t1 frame ok", rx_ok_q.size() > 0 ? int'(rx_ok_q[0]) : 0, 1);
        chk("t1 start", rx_start_q.size() > 0 ? rx_start_q[0] - t0 : -1, 2);
        chk("t1 first fall", rx_fall_q.size() > 0 ? rx_fall_q[0] - t0 : -1, 6);
        chk("t1 duration", rx_end_q.size() > 0 ? rx_end_q[0] - rx_start_q[0] : -1, 88);

        for (int i = 0; i < 7; i++) begin
            clear_rx();
            flip(vecs[i].ext, vecs[i].pressed, vecs[i].code);
            wait_idle($sformatf("v%0d", i), 1000);
            eb[0] = vecs[i].b0;
            eb[1] = vecs[i].b1;
            eb[2] = vecs[i].b2;
            chk($sformatf("v%0d frame count", i), rx_q.size(), vecs[i].n);
            for (int j = 0; j < vecs[i].n; j++) begin
                if (j < rx_q.size()) begin
                    chk($sformatf("v%0d byte%0d", i, j), rx_q[j], eb[j]);
                    chk($sformatf("v%0d frame%0d ok", i, j), rx_ok_q[j], 1);
                    chk($sformatf("v%0d frame%0d duration", i, j), rx_end_q[j] - rx_start_q[j], 22 * HALF);
                    if (j > 0)
                        chk($sformatf("v%0d frame%0d separation", i, j), rx_start_q[j] - rx_end_q[j-1], GAP + 1);
                end
            end
        end

        // Inhibited line: five 3-byte events fit, the sixth is dropped whole.
        clear_rx();
        host_clk = 1'b0;
        o0 = ovf_cnt;
        for (int e = 0; e < 5; e++) begin
            flip(1'b1, 1'b0, 8'h10 + 8'(e));
            step(5);
        end
        chk("ovf busy while inhibited", busy, 1);
        chk("ovf none for 15 bytes", ovf_cnt - o0, 0);
        flip(1'b1, 1'b0, 8'h99);
        step(1);
        chk("ovf pulse high", overflow, 1);
        step(1);
        chk("ovf pulse low", overflow, 0);
        step(5);
        chk("ovf pulse count", ovf_cnt - o0, 1);
        chk("ovf nothing sent while inhibited", rx_q.size(), 0);
        host_clk = 1'b1;
        wait_idle("ovf drain", 3000);
        chk("ovf frame count", rx_q.size(), 15);
        for (int j = 0; j < 15 && j < rx_q.size(); j++) begin
            exp_b = (j % 3 == 0) ? 8'hE0 : (j % 3 == 1) ? 8'hF0 : 8'h10 + 8'(j / 3);
            chk($sformatf("ovf byte%0d", j), rx_q[j], exp_b);
        end

        // Host pulls the clock low mid-byte; the byte restarts after the line has been high long enough.
        clear_rx();
        flip(1'b1, 1'b1, 8'h74);
        k = 0;
        while (!(rx_n == 4 && ps2_kbd_clk_out) && k < 200) begin
            step(1);
            k++;
        end
        chk("inh reached idx4", rx_n, 4);
        host_clk = 1'b0;
        step(1);
        chk("inh clk released", ps2_kbd_clk_out, 1);
        chk("inh dat released", ps2_kbd_dat_out, 1);
        step(10);
        chk("inh busy held", busy, 1);
        host_clk = 1'b1;
        r = cyc;
        k = 0;
        while (cur_start < r && k < 50) begin
            step(1);
            k++;
        end
        chk("inh restart delay", cur_start - r, GAP + 1);
        wait_idle("inh", 1000);
        chk("inh frame count", rx_q.size(), 2);
        chk("inh byte0", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 8'hE0);
        chk("inh byte1", rx_q.size() > 1 ? int'(rx_q[1]) : -1, 8'h74);

        // Reset in the middle of bit 6, then release it with an unprocessed-looking toggle.
        clear_rx();
        flip(1'b1, 1'b0, 8'h33);
        k = 0;
        while (!(rx_n == 7 && !ps2_kbd_clk_out) && k < 200) begin
            step(1);
            k++;
        end
        chk("rst reached idx6 low", rx_n, 7);
        reset = 1'b1;
        step(1);
        chk("rst clk_out", ps2_kbd_clk_out, 1);
        chk("rst dat_out", ps2_kbd_dat_out, 1);
        chk("rst busy", busy, 0);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2A};
        step(2);
        reset = 1'b0;
        o0 = ovf_cnt;
        f0 = fall_cnt;
        step(200);
        chk("rst no frames", rx_q.size(), 0);
        chk("rst no clock edges", fall_cnt - f0, 0);
        chk("rst no overflow", ovf_cnt - o0, 0);
        chk("rst idle", busy, 0);
        flip(1'b0, 1'b1, 8'h2A);
        wait_idle("post reset", 1000);
        chk("post reset frame count", rx_q.size(), 1);
        chk("post reset byte", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 8'h2A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_transmitter.md
# ps2_key_transmitter

Device-side PS/2 keyboard serializer. It converts the 11-bit `ps2_key` event word from `hps_io` into Set-2 scancode bytes (E0 prefix, F0 break prefix, code), buffers them, and clocks them out as standard 11-bit PS/2 device-to-host frames. It sits between `hps_io` and the Next186Lite core's keyboard port, so the core's PS/2 receiver sees a real keyboard line. It honours host inhibit: the host may hold the clock line low at any time.

## Interface
Parameters:
- `HALF`, default 1500: `clk_sys` cycles per PS/2 clock half-period (low or high).
- `GAP`, default 3000: idle `clk_sys` cycles between frames. Also the required clock-high time after an inhibit.
- `DEPTH`, default 16: byte FIFO depth. Must be a power of two.

Ports (clock and reset first):
- `clk_sys`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `ps2_key`, in, 11: `[7:0]` code, `[8]` extended, `[9]` pressed, `[10]` toggle. A new event is signalled by a change of `[10]`.
- `ps2_kbd_clk_in`, in, 1: sampled PS/2 clock line (host may pull it low).
- `ps2_kbd_clk_out`, out, 1: clock drive. 1 means released/high.
- `ps2_kbd_dat_out`, out, 1: data drive. 1 means released/high.
- `busy`, out, 1: high while the FIFO is non-empty or the FSM is not IDLE.
- `overflow`, out, 1: one-cycle pulse when an event is dropped.

## Operation
**Event capture**
- Register `last_tog` holds the last processed toggle value. On reset it loads `ps2_key[10]`, so a stale toggle never emits a frame.
- When the enqueue sequencer is idle and `ps2_key[10] != last_tog`, the block latches the event and updates `last_tog`.
- Byte count n = 1 + `[8]` + !`[9]`. Byte order is E0 (if extended), then F0 (if release), then code.
- If FIFO free slots < n, the whole event is dropped and `overflow` pulses. Partial events are never written.
- Accepted bytes are written one per cycle.
- `ps2_key` is stable while its toggle is unprocessed, so no second latch is needed.

**Frame**
- 11 bits: start 0, data[0..7] LSB first, parity = `~^data` (odd), stop 1.

**FSM states**
- IDLE: lines released. If the FIFO is non-empty and `ps2_kbd_clk_in` = 1, load the frame from the FIFO head, set idx = 0, go to BIT_HI.
- BIT_HI: clock released, data = frame[idx], for HALF cycles.
  - If `ps2_kbd_clk_in` = 0 is seen in any BIT_HI cycle with idx ≤ 9, go to INHIBIT.
  - Otherwise go to BIT_LO.
- BIT_LO: clock driven 0, data held, for HALF cycles. Then idx++. If idx = 11, pop the FIFO and go to GAP; else go to BIT_HI.
- GAP: lines released for GAP cycles, then go to IDLE.
- INHIBIT: lines released, FIFO head not popped. Counter resets whenever `ps2_kbd_clk_in` = 0. After GAP consecutive high cycles, go to IDLE, which retransmits the same byte from the start bit.

**Reset**
- Reset mid-frame: FSM goes to IDLE, FIFO is emptied, counters are cleared.

## Timing
- Reset values: `ps2_kbd_clk_out` = 1, `ps2_kbd_dat_out` = 1, `busy` = 0, `overflow` = 0. FIFO empty, FSM IDLE.
- Toggle change visible at cycle T, line idle, FIFO empty:
  - First byte written at T+1.
  - BIT_HI entered at T+2 with data = 0.
  - First falling clock edge at T+2+HALF.
- Frame duration is 22·HALF cycles. Next frame start (BIT_HI) at frame end + GAP + 1.
- Data changes only on the cycle the FSM enters BIT_HI, i.e. while the clock is high, ≥ HALF cycles before the falling edge.
- `overflow` is asserted in the cycle after the toggle is detected, for exactly one cycle.
- An inhibit reaction reaches the outputs one cycle after the low sample.

## Structure
- Package `ps2_tx_pkg` holds:
  - `PS2_EXT` = 8'hE0, `PS2_BRK` = 8'hF0, `FRAME_BITS` = 11.
  - The FSM enum {IDLE, BIT_HI, BIT_LO, GAP, INHIBIT}.
- Sub-module `ps2_byte_fifo`: synchronous FIFO, 8-bit, DEPTH entries, with `wr`, `rd`, `empty`, and a `free` count. Pointers wrap modulo DEPTH. A simultaneous write and pop is legal when full, and the count is unchanged.
- Top-level module: toggle capture, enqueue sequencer, transmit FSM.

## Test plan
Bench parameters: HALF = 4, GAP = 8.
1. Pressed, non-extended, code 8'h1C, toggle flipped:
   - One frame: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1.
   - First clock fall at T+6. Frame is 88 cycles.
   - `busy` clears after GAP.
2. Released, extended, code 8'h75:
   - Frames E0 (parity 0), F0 (parity 1), 75 (parity 0), in that order.
   - Each frame start is separated from the previous frame's end by 9 cycles.
3. Hold `ps2_kbd_clk_in` = 0 and issue six released-extended events (18 bytes):
   - First five events (15 bytes) are accepted.
   - Sixth event gives a single `overflow` pulse and no bytes written.
   - After release, exactly 15 frames are sent.
4. Pull `ps2_kbd_clk_in` low during BIT_HI at idx = 4:
   - Lines are released next cycle.
   - After 8 consecutive high cycles, the same byte restarts from the start bit.
   - No byte is lost or duplicated.
5. Assert reset during idx = 6:
   - Both outputs are 1 the next cycle.
   - FIFO is empty and no further frames are sent.
6. Release reset with `ps2_key[10]` = 1 and a stable `ps2_key`:
   - No frame and no `overflow`.
   - A subsequent toggle emits exactly one event.
